// File: rtl/serial_mag_compare.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_mag_compare: MSB-first 2-bit-per-clock unsigned magnitude compare |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  output logic                        busy,
  output logic                        done,
  output logic                        lt,
  output logic                        gt,
  output logic                        eq,
  output logic [$clog2(WIDTH/2):0]    slices
);

  localparam int S    = WIDTH / 2;
  localparam int IDXW = (S > 1) ? $clog2(S) : 1;
  localparam int SW   = $clog2(S) + 1;
  localparam logic [IDXW-1:0] C_IDX_TOP = IDXW'(S - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, r_b, w_a_nxt, w_b_nxt;
  logic [IDXW-1:0]   r_idx, w_idx_nxt;
  logic [SW-1:0]     r_slices, w_slices_nxt;
  logic              r_busy, r_done, r_lt, r_gt, r_eq;
  logic              w_lt_nxt, w_gt_nxt, w_eq_nxt;
  logic [1:0]        w_a_sl, w_b_sl;

  assign w_a_sl = r_a[{r_idx, 1'b0} +: 2];
  assign w_b_sl = r_b[{r_idx, 1'b0} +: 2];

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_idx_nxt    = r_idx;
    w_slices_nxt = r_slices;
    w_lt_nxt     = r_lt;
    w_gt_nxt     = r_gt;
    w_eq_nxt     = r_eq;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new start exactly like IDLE for back-to-back use
        if (start) begin
          w_a_nxt      = a;
          w_b_nxt      = b;
          w_idx_nxt    = C_IDX_TOP;
          w_slices_nxt = '0;
          w_lt_nxt     = 1'b0;
          w_gt_nxt     = 1'b0;
          w_eq_nxt     = 1'b0;
          w_state_nxt  = ST_RUN;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_slices_nxt = r_slices + SW'(1);
        if (w_a_sl > w_b_sl) begin
          w_gt_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_a_sl < w_b_sl) begin
          w_lt_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_idx == '0) begin
          w_eq_nxt    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx - IDXW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_slices <= '0;
      r_lt     <= 1'b0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_idx    <= w_idx_nxt;
      r_slices <= w_slices_nxt;
      r_lt     <= w_lt_nxt;
      r_gt     <= w_gt_nxt;
      r_eq     <= w_eq_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_done   <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign lt     = r_lt;
  assign gt     = r_gt;
  assign eq     = r_eq;
  assign slices = r_slices;

endmodule
`default_nettype wire
